freq_meter: RTL

Gated frequency meter for the theremin's sensing path: counts rising edges of an asynchronous oscillator input (`sig_in`) over a fixed window of `GATE_CYCLES` system clocks and publishes the count once per window. It is the measurement-side counterpart of the clock divider. The divider derives a slow clock from `clk`; this block measures an external clock against `clk`. It feeds the pitch/volume mapping logic downstream.

---
 rtl/theremin_pkg.sv | 29 ++
 rtl/sync_edge_det.sv | 37 +++
 rtl/freq_meter.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/theremin_pkg.sv
// -----------------------------------------------------------------------------
// theremin_pkg
// Shared constants for the theremin datapath.
//   - FM_IDLE / FM_GATE / FM_LATCH : 2-bit state codes of the frequency meter
//   - fm_state_t                   : enum built on those codes
//   - GATE_CYCLES_100M / _50M      : 10 ms window lengths for 100 MHz and 50 MHz
//                                    system clocks; the clock divider derives its
//                                    k constants from the same clock rates
// -----------------------------------------------------------------------------
package theremin_pkg;

    localparam logic [1:0] FM_IDLE  = 2'd0;
    localparam logic [1:0] FM_GATE  = 2'd1;
    localparam logic [1:0] FM_LATCH = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = FM_IDLE,
        ST_GATE  = FM_GATE,
        ST_LATCH = FM_LATCH
    } fm_state_t;

    localparam int unsigned SYS_CLK_100M_HZ  = 100_000_000;
    localparam int unsigned SYS_CLK_50M_HZ   = 50_000_000;

    // 10 ms measurement window at each system clock rate
    localparam int unsigned GATE_CYCLES_100M = SYS_CLK_100M_HZ / 100;
    localparam int unsigned GATE_CYCLES_50M  = SYS_CLK_50M_HZ / 100;

endpackage : theremin_pkg

// File: rtl/sync_edge_det.sv
// -----------------------------------------------------------------------------
// sync_edge_det
// Brings an asynchronous level into the clk domain through two flops, then
// delays it once more so a rising edge can be detected.
//   clk     : system clock
//   rst     : asynchronous active-low reset, clears all three flops
//   d_async : asynchronous input level
//   rise    : high for one clk cycle per synchronized rising edge
// -----------------------------------------------------------------------------
module sync_edge_det
    import theremin_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic d_async,
    output logic rise
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= d_async;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign rise = r_s2 & ~r_s3;

endmodule : sync_edge_det

// File: rtl/freq_meter.sv
// -----------------------------------------------------------------------------
// freq_meter
// Gated frequency meter: counts rising edges of sig_in over GATE_CYCLES clk
// cycles and publishes the total once per window.
//   clk    : system clock
//   rst    : asynchronous active-low reset
//   en     : measurement enable (clk domain)
//   sig_in : oscillator input, asynchronous to clk
//   count  : rising-edge count of the last completed window
//   valid  : one-cycle pulse coincident with count/ovf updating
//   ovf    : last completed window saturated the edge counter
//   busy   : high while a window is open
// -----------------------------------------------------------------------------
module freq_meter
    import theremin_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = GATE_CYCLES_100M,
    parameter int unsigned GATE_W      = 26,
    parameter int unsigned CNT_W       = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] count,
    output logic             valid,
    output logic             ovf,
    output logic             busy
);

    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    logic w_rise;

    fm_state_t        r_state;
    fm_state_t        w_state_next;
    logic [GATE_W-1:0] r_gate_cnt;
    logic [GATE_W-1:0] w_gate_cnt_next;
    logic [CNT_W-1:0]  r_edge_cnt;
    logic [CNT_W-1:0]  w_edge_cnt_next;
    logic              r_ovf_int;
    logic              w_ovf_int_next;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  w_count_next;
    logic              r_ovf;
    logic              w_ovf_next;
    logic              r_valid;
    logic              w_valid_next;
    logic              r_busy;
    logic              w_busy_next;

    sync_edge_det u_sync (
        .clk     (clk),
        .rst     (rst),
        .d_async (sig_in),
        .rise    (w_rise)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
            r_ovf_int  <= 1'b0;
            r_count    <= '0;
            r_ovf      <= 1'b0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_gate_cnt <= w_gate_cnt_next;
            r_edge_cnt <= w_edge_cnt_next;
            r_ovf_int  <= w_ovf_int_next;
            r_count    <= w_count_next;
            r_ovf      <= w_ovf_next;
            r_valid    <= w_valid_next;
            r_busy     <= w_busy_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_gate_cnt_next = r_gate_cnt;
        w_edge_cnt_next = r_edge_cnt;
        w_ovf_int_next  = r_ovf_int;
        w_count_next    = r_count;
        w_ovf_next      = r_ovf;
        w_valid_next    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_gate_cnt_next = '0;
                w_edge_cnt_next = '0;
                w_ovf_int_next  = 1'b0;
                if (en) begin
                    w_state_next = ST_GATE;
                end
            end

            ST_GATE: begin
                if (!en) begin
                    // Abort: discard the partial window, published result untouched
                    w_state_next    = ST_IDLE;
                    w_gate_cnt_next = '0;
                    w_edge_cnt_next = '0;
                    w_ovf_int_next  = 1'b0;
                end else begin
                    w_gate_cnt_next = r_gate_cnt + 1'b1;
                    if (w_rise) begin
                        if (r_edge_cnt == CNT_MAX) begin
                            w_ovf_int_next = 1'b1;
                        end else begin
                            w_edge_cnt_next = r_edge_cnt + 1'b1;
                        end
                    end
                    if (r_gate_cnt == GATE_LAST) begin
                        w_state_next = ST_LATCH;
                    end
                end
            end

            ST_LATCH: begin
                // valid is registered alongside count/ovf so all three change
                // together; any rise seen in this cycle is intentionally lost.
                w_count_next    = r_edge_cnt;
                w_ovf_next      = r_ovf_int;
                w_valid_next    = 1'b1;
                w_gate_cnt_next = '0;
                w_edge_cnt_next = '0;
                w_ovf_int_next  = 1'b0;
                w_state_next    = en ? ST_GATE : ST_IDLE;
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        w_busy_next = (w_state_next == ST_GATE);
    end

    assign count = r_count;
    assign valid = r_valid;
    assign ovf   = r_ovf;
    assign busy  = r_busy;

endmodule : freq_meter
